extbus_responder: RTL and testbench



---
 rtl/extbus_pkg.sv | 46 ++++
 rtl/extbus_responder.sv | 184 ++++++++++++++++++
 tb/tb_extbus_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/extbus_pkg.sv
// Shared definitions for the external-bus mailbox responder: slot map, status codes,
// command/status field positions and the controller state encoding.
package extbus_pkg;

  localparam int DATA_W = 72;

  localparam logic [1:0] SLOT_CMD   = 2'd0;
  localparam logic [1:0] SLOT_WDATA = 2'd1;
  localparam logic [1:0] SLOT_RDATA = 2'd2;
  localparam logic [1:0] SLOT_STAT  = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BADOP   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam int CMD_WE_BIT  = 20;
  localparam int CMD_OP_LSB  = 21;
  localparam int CMD_OP_MSB  = 23;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;
  localparam int STAT_CODE_LSB = 2;
  localparam int STAT_SEQ_LSB  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CMD,
    S_RD_DATA,
    S_MEM,
    S_WR_RES,
    S_WR_STAT,
    S_DONE
  } state_e;

  function automatic logic [DATA_W-1:0] status_word(input logic [1:0] code,
                                                     input logic [7:0] seq);
    logic [DATA_W-1:0] w;
    w                        = '0;
    w[STAT_DONE_BIT]         = 1'b1;
    w[STAT_ERR_BIT]          = (code != ST_OK);
    w[STAT_CODE_LSB +: 2]    = code;
    w[STAT_SEQ_LSB +: 8]     = seq;
    return w;
  endfunction

endpackage

// File: rtl/extbus_responder.sv
// Memory-side agent for the 4-slot external bus mailbox: fetch command, run one memory
// access, post result and status. Optional mem_ack watchdog: EXTBUS_RESPONDER_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for start
// RD_CMD    | read slot 0, decode command
// RD_DATA   | read slot 1 (write data)
// MEM       | memory request held until mem_ack (or watchdog)
// WR_RES    | write read data to slot 2
// WR_STAT   | write status to slot 3, bump sequence number
// DONE      | one-cycle done pulse
module extbus_responder
  import extbus_pkg::*;
#(
  parameter int ADDR_W = 20
`ifdef EXTBUS_RESPONDER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        pA,
  output logic              pEC,
  output logic              pW,
  input  logic [DATA_W-1:0] pDin,
  output logic [DATA_W-1:0] pDout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          code_q, code_d;
  logic [7:0]          seq_q, seq_d;

`ifdef EXTBUS_RESPONDER_TIMEOUT_EN
  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmr_q, tmr_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      code_q  <= ST_OK;
      seq_q   <= '0;
`ifdef EXTBUS_RESPONDER_TIMEOUT_EN
      tmr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      seq_q   <= seq_d;
`ifdef EXTBUS_RESPONDER_TIMEOUT_EN
      tmr_q   <= tmr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    code_d    = code_q;
    seq_d     = seq_q;
`ifdef EXTBUS_RESPONDER_TIMEOUT_EN
    tmr_d     = TMR_LOAD;
`endif
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    pA        = SLOT_CMD;
    pEC       = 1'b0;
    pW        = 1'b0;
    pDout     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_CMD;
          code_d  = ST_OK;
        end
      end
      S_RD_CMD: begin
        pA     = SLOT_CMD;
        pEC    = 1'b1;
        addr_d = pDin[ADDR_W-1:0];
        we_d   = pDin[CMD_WE_BIT];
        if (pDin[CMD_OP_MSB:CMD_OP_LSB] != 3'd0) begin
          code_d  = ST_BADOP;
          state_d = S_WR_STAT;
        end else if (pDin[CMD_WE_BIT]) begin
          state_d = S_RD_DATA;
        end else begin
          state_d = S_MEM;
        end
      end
      S_RD_DATA: begin
        pA      = SLOT_WDATA;
        pEC     = 1'b1;
        wdata_d = pDin;
        state_d = S_MEM;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack) begin
          if (we_q) begin
            state_d = S_WR_STAT;
          end else begin
            rdata_d = mem_rdata;
            state_d = S_WR_RES;
          end
`ifdef EXTBUS_RESPONDER_TIMEOUT_EN
        end else if (tmr_q == 16'd0) begin
          code_d  = ST_TIMEOUT;
          state_d = S_WR_STAT;
        end else begin
          tmr_d   = tmr_q - 16'd1;
`endif
        end
      end
      S_WR_RES: begin
        pA      = SLOT_RDATA;
        pEC     = 1'b1;
        pW      = 1'b1;
        pDout   = rdata_q;
        state_d = S_WR_STAT;
      end
      S_WR_STAT: begin
        pA      = SLOT_STAT;
        pEC     = 1'b1;
        pW      = 1'b1;
        pDout   = status_word(code_q, seq_q);
        seq_d   = seq_q + 8'd1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet for the whole time reset is held, not just after the edge.
    if (!reset_n) begin
      busy      = 1'b0;
      done      = 1'b0;
      pA        = '0;
      pEC       = 1'b0;
      pW        = 1'b0;
      pDout     = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

endmodule

// File: tb/tb_extbus_responder.sv
// Bench for extbus_responder: mailbox and memory models, table-driven transactions
// and a scoreboard of expected mailbox writes.
module tb_extbus_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pEC, pW, mem_req, mem_we;
  logic [1:0]  pA;
  logic [71:0] pDin, pDout, mem_wdata;
  logic [71:0] mem_rdata = '0;
  logic [19:0] mem_addr;
  logic        model_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic        mem_ack;

  logic [71:0] slot0_v = '0, slot1_v = '0;
  logic [71:0] slot2_q = '0, slot3_q = '0;

  assign mem_ack = model_ack | stray_ack;
  assign pDin = (pA == 2'd0) ? slot0_v : (pA == 2'd1) ? slot1_v :
                (pA == 2'd2) ? slot2_q : slot3_q;

  extbus_responder #(
    .ADDR_W(20)
`ifdef EXTBUS_RESPONDER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .pA(pA), .pEC(pEC), .pW(pW), .pDin(pDin), .pDout(pDout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && pEC && pW) begin
      if (pA == 2'd2) slot2_q <= pDout;
      if (pA == 2'd3) slot3_q <= pDout;
    end
  end

  typedef struct {
    logic [1:0]  slot;
    logic [71:0] data;
  } exp_t;

  typedef struct {
    logic [71:0] cmd;
    logic [71:0] wdata;
    logic [71:0] rdata;
    int          delay;
    logic [19:0] exp_addr;
    logic        exp_we;
    logic [1:0]  exp_code;
    int          exp_lat;
  } vec_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  model_seq = '0;
  int          ack_delay = 1;
  logic [71:0] rd_value = '0;
  int          req_cnt = 0;
  int          last_len = 0;
  int          req_starts = 0;
  logic [19:0] cap_addr = '0;
  logic        cap_we = 1'b0;
  logic [71:0] cap_wdata = '0;

  function automatic logic [71:0] stat(input logic [1:0] code, input logic [7:0] seq);
    return {56'd0, seq, 4'd0, code, (code != 2'd0), 1'b1};
  endfunction

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // One cycle: memory model and scoreboard both act on negedge samples.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (mem_req) begin
      if (req_cnt == 0) req_starts++;
      req_cnt++;
      cap_addr  = mem_addr;
      cap_we    = mem_we;
      cap_wdata = mem_wdata;
      model_ack = (ack_delay != 0) && (req_cnt == ack_delay);
    end else begin
      if (req_cnt != 0) last_len = req_cnt;
      req_cnt   = 0;
      model_ack = 1'b0;
    end
    mem_rdata = rd_value;
    if (pEC && pW) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected_write: got slot %0d data %h expected no write", pA, pDout);
      end else begin
        e = exp_q.pop_front();
        if (pA !== e.slot || pDout !== e.data) begin
          n_errors++;
          $display("FAIL sb_write: got slot %0d data %h expected slot %0d data %h",
                   pA, pDout, e.slot, e.data);
        end
      end
    end
  endtask

  // extra: 0 none, 1 start again while busy, 2 start during the DONE cycle
  task automatic run_txn(input vec_t v, input int extra, input string nm);
    int cyc;
    int starts0;
    slot0_v   = v.cmd;
    slot1_v   = v.wdata;
    rd_value  = v.rdata;
    ack_delay = v.delay;
    starts0   = req_starts;
    if (v.exp_code == 2'd0 && !v.exp_we) exp_q.push_back('{2'd2, v.rdata});
    exp_q.push_back('{2'd3, stat(v.exp_code, model_seq)});
    model_seq = model_seq + 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, "_busy"}, 72'(busy), 72'(1));
    cyc = 1;
    while (!done && cyc < 200) begin
      start = (extra == 1 && cyc == 3);
      tick();
      cyc++;
    end
    start = 1'b0;
    check({nm, "_latency"}, 72'(cyc), 72'(v.exp_lat));
    if (v.exp_code != 2'd1) begin
      check({nm, "_addr"}, 72'(cap_addr), 72'(v.exp_addr));
      check({nm, "_we"}, 72'(cap_we), 72'(v.exp_we));
      if (v.exp_we) check({nm, "_wdata"}, cap_wdata, v.wdata);
    end
    if (extra == 2) start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, "_done_pulse"}, 72'(done), 72'(0));
    check({nm, "_idle"}, 72'(busy), 72'(0));
    if (extra != 0) begin
      repeat (4) tick();
      check({nm, "_no_second"}, 72'(busy), 72'(0));
    end
    check({nm, "_req_count"}, 72'(req_starts - starts0), 72'((v.exp_code == 2'd1) ? 0 : 1));
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   k;
    logic [7:0] seq_before;

    vecs[0] = '{72'h12345, 72'h0, 72'hAB_CDEF0123_456789AB, 1, 20'h12345, 1'b0, 2'd0, 5};
    vecs[1] = '{72'h10_0FF0, 72'h555555555555555555, 72'h0, 1, 20'h00FF0, 1'b1, 2'd0, 5};
    vecs[2] = '{72'hA0_0001, 72'h0, 72'h0, 1, 20'h00001, 1'b0, 2'd1, 3};
    vecs[3] = '{72'hFF_FFFF_FFFF_FF0F_FFFF, 72'h0, 72'h0, 3, 20'hFFFFF, 1'b0, 2'd0, 7};
    vecs[4] = '{72'h1A_BCDE, 72'hFE_DCBA9876_543210AA, 72'h0, 2, 20'hABCDE, 1'b1, 2'd0, 6};
    vecs[5] = '{72'hF0_0000, 72'h0, 72'h0, 1, 20'h00000, 1'b0, 2'd1, 3};

    repeat (3) tick();
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_done", 72'(done), 72'(0));
    check("rst_port", {69'd0, pEC, pW, mem_req}, 72'd0);
    check("rst_data", pDout | mem_wdata | 72'(mem_addr), 72'd0);
    reset_n = 1'b1;
    tick();
    check("idle_busy", 72'(busy), 72'(0));

    for (int i = 0; i < 6; i++) run_txn(vecs[i], 0, $sformatf("vec%0d", i));

    v = '{72'h0_0777, 72'h0, 72'h0123_4567_89AB_CDEF_11, 10, 20'h00777, 1'b0, 2'd0, 14};
    run_txn(v, 1, "busy_start");
    check("busy_req_len", 72'(last_len), 72'(10));

    v = '{72'h0_0042, 72'h0, 72'h33, 1, 20'h00042, 1'b0, 2'd0, 5};
    run_txn(v, 2, "done_start");

    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick();
    check("stray_ack_busy", 72'(busy), 72'(0));
    check("stray_ack_req", 72'(mem_req), 72'(0));

    slot0_v = 72'h0_0999;
    ack_delay = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!mem_req && k < 20) begin
      tick();
      k++;
    end
    check("rstmem_reached", 72'(mem_req), 72'(1));
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    check("rstmem_req", 72'(mem_req), 72'(0));
    check("rstmem_busy", 72'(busy), 72'(0));
    reset_n = 1'b1;
    model_seq = '0;
    repeat (2) tick();
    check("rstmem_req_after", 72'(mem_req), 72'(0));
    check("rstmem_busy_after", 72'(busy), 72'(0));

    v = '{72'h0_0100, 72'h0, 72'hC0FFEE, 1, 20'h00100, 1'b0, 2'd0, 5};
    run_txn(v, 0, "post_rst");
    check("post_rst_seq", 72'(slot3_q[15:8]), 72'(0));

    seq_before = model_seq;
    for (int i = 0; i < 256; i++) begin
      v.exp_addr = 20'($urandom_range(0, 20'hFFFFF));
      v.exp_we   = 1'($urandom_range(0, 1));
      v.cmd      = {48'($urandom), 3'b000, v.exp_we, v.exp_addr};
      v.wdata    = {8'($urandom), $urandom, $urandom};
      v.rdata    = {8'($urandom), $urandom, $urandom};
      v.delay    = $urandom_range(1, 3);
      v.exp_code = 2'd0;
      v.exp_lat  = v.delay + 4;
      run_txn(v, 0, "wrap");
    end
    v = '{72'hA0_0000, 72'h0, 72'h0, 1, 20'h0, 1'b0, 2'd1, 3};
    run_txn(v, 0, "wrap_final");
    check("wrap_seq", 72'(slot3_q[15:8]), 72'(seq_before));

`ifdef EXTBUS_RESPONDER_TIMEOUT_EN
    v = '{72'h0_0555, 72'h0, 72'h0, 0, 20'h00555, 1'b0, 2'd2, 7};
    run_txn(v, 0, "timeout_rd");
    check("timeout_req_len", 72'(last_len), 72'(4));
    check("timeout_stat", slot3_q, stat(2'd2, model_seq - 8'd1));
    v = '{72'h10_0556, 72'h77, 72'h0, 0, 20'h00556, 1'b1, 2'd2, 8};
    run_txn(v, 0, "timeout_wr");
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick();
    check("timeout_late_ack", 72'(busy), 72'(0));
`endif

    check("sb_drained", 72'(exp_q.size()), 72'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
